// File: rtl/wishbone_pkg.sv
// ---------------------------------------------------------------------------
// wishbone_pkg
// Shared types and bus widths for the Wishbone manager-side arbiter.
//   arb_state_t : arbiter FSM states (IDLE, OWNED, FORCE)
//   WB_ADR_W    : address width
//   WB_DAT_W    : data width
//   WB_SEL_W    : byte-select width
// ---------------------------------------------------------------------------
package wishbone_pkg;

    localparam int WB_ADR_W = 32;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no owner; arbitrate among raised cyc lines
        OWNED = 2'd1,   // one manager owns the downstream port
        FORCE = 2'd2    // one-cycle synthetic ack after a watchdog expiry
    } arb_state_t;

endpackage : wishbone_pkg

// File: rtl/rr_arbiter_core.sv
// ---------------------------------------------------------------------------
// rr_arbiter_core
// Purely combinational round-robin pick: searches req_i starting at ptr_i,
// moving upward and wrapping, and returns the first requester found.
//   req_i       in   NUM_MANAGERS  request vector
//   ptr_i       in   IDX_W         index that has highest priority
//   grant_o     out  NUM_MANAGERS  one-hot winner (0 when no request)
//   grant_idx_o out  IDX_W         binary index of the winner
//   valid_o     out  1             at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter_core #(
    parameter int NUM_MANAGERS = 3,
    parameter int IDX_W        = $clog2(NUM_MANAGERS)
) (
    input  logic [NUM_MANAGERS-1:0] req_i,
    input  logic [IDX_W-1:0]        ptr_i,
    output logic [NUM_MANAGERS-1:0] grant_o,
    output logic [IDX_W-1:0]        grant_idx_o,
    output logic                    valid_o
);

    // One extra bit so ptr + offset cannot overflow before the modulo wrap.
    localparam int SUM_W = IDX_W + 1;

    logic [SUM_W-1:0] sum;
    logic [IDX_W-1:0] cand;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves one unassigned infers a latch.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        valid_o     = 1'b0;
        sum         = '0;
        cand        = '0;
        for (int i = 0; i < NUM_MANAGERS; i++) begin
            sum = {1'b0, ptr_i} + SUM_W'(i);
            if (sum >= SUM_W'(NUM_MANAGERS)) begin
                sum = sum - SUM_W'(NUM_MANAGERS);
            end
            cand = sum[IDX_W-1:0];
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                grant_idx_o   = cand;
            end
        end
    end

endmodule : rr_arbiter_core

// File: rtl/wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// wishbone_arbiter
// Shares one Wishbone manager port among NUM_MANAGERS bus masters.
// Round-robin grant held for the whole cyc; a watchdog forces an ack with
// TIMEOUT_DATA if the decoder never answers a strobe.
//   CLK, RST          clock, asynchronous active-high reset
//   wbs_*_i_mgr       per-manager request side (flat, manager k at slice k)
//   wbs_ack_o_mgr     ack routed to the owner only
//   wbs_dat_o_mgr     read data to the owner, 0 for everyone else
//   wbs_*_o_m         downstream request to the decoder
//   wbs_ack_i_m/dat   downstream response from the decoder
//   grant_o           one-hot current owner
//   timeout_o         one-cycle pulse per forced ack
// ---------------------------------------------------------------------------
module wishbone_arbiter
    import wishbone_pkg::*;
#(
    parameter int                  NUM_MANAGERS   = 3,
    parameter int                  TIMEOUT_CYCLES = 1024,
    parameter logic [WB_DAT_W-1:0] TIMEOUT_DATA   = 32'hDEAD_BEEF
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_MANAGERS-1:0]        wbs_cyc_i_mgr,
    input  logic [NUM_MANAGERS-1:0]        wbs_stb_i_mgr,
    input  logic [NUM_MANAGERS-1:0]        wbs_we_i_mgr,
    input  logic [WB_ADR_W*NUM_MANAGERS-1:0] wbs_adr_i_mgr,
    input  logic [WB_DAT_W*NUM_MANAGERS-1:0] wbs_dat_i_mgr,
    input  logic [WB_SEL_W*NUM_MANAGERS-1:0] wbs_sel_i_mgr,
    output logic [NUM_MANAGERS-1:0]        wbs_ack_o_mgr,
    output logic [WB_DAT_W*NUM_MANAGERS-1:0] wbs_dat_o_mgr,
    output logic                           wbs_cyc_o_m,
    output logic                           wbs_stb_o_m,
    output logic                           wbs_we_o_m,
    output logic [WB_ADR_W-1:0]            wbs_adr_o_m,
    output logic [WB_DAT_W-1:0]            wbs_dat_o_m,
    output logic [WB_SEL_W-1:0]            wbs_sel_o_m,
    input  logic                           wbs_ack_i_m,
    input  logic [WB_DAT_W-1:0]            wbs_dat_i_m,
    output logic [NUM_MANAGERS-1:0]        grant_o,
    output logic                           timeout_o
);

    localparam int              IDX_W   = $clog2(NUM_MANAGERS);
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_MANAGERS - 1);

    arb_state_t              state_q, state_d;
    logic [NUM_MANAGERS-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]        owner_q, owner_d;
    logic [IDX_W-1:0]        ptr_q,   ptr_d;
    logic [WD_W-1:0]         wd_q,    wd_d;

    logic [NUM_MANAGERS-1:0] rr_grant;
    logic [IDX_W-1:0]        rr_idx;
    logic                    rr_valid;

    rr_arbiter_core #(
        .NUM_MANAGERS (NUM_MANAGERS),
        .IDX_W        (IDX_W)
    ) u_rr (
        .req_i       (wbs_cyc_i_mgr),
        .ptr_i       (ptr_q),
        .grant_o     (rr_grant),
        .grant_idx_o (rr_idx),
        .valid_o     (rr_valid)
    );

    // Owner's handshake lines; only meaningful outside IDLE.
    logic own_cyc, own_stb;
    assign own_cyc = wbs_cyc_i_mgr[owner_q];
    assign own_stb = wbs_stb_i_mgr[owner_q];

    // ---------------- state register ----------------
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                if (rr_valid) begin
                    state_d = OWNED;
                    grant_d = rr_grant;
                    owner_d = rr_idx;
                    wd_d    = '0;
                end
            end
            OWNED: begin
                if (!own_cyc) begin
                    // Release: next search starts just above the old owner.
                    state_d = IDLE;
                    grant_d = '0;
                    wd_d    = '0;
                    ptr_d   = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
                end else if (wbs_ack_i_m || !own_stb) begin
                    wd_d = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d = FORCE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            FORCE: begin
                state_d = OWNED;
                wd_d    = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        wbs_cyc_o_m   = 1'b0;
        wbs_stb_o_m   = 1'b0;
        wbs_we_o_m    = 1'b0;
        wbs_adr_o_m   = '0;
        wbs_dat_o_m   = '0;
        wbs_sel_o_m   = '0;
        wbs_ack_o_mgr = '0;
        wbs_dat_o_mgr = '0;
        timeout_o     = 1'b0;
        if (state_q != IDLE) begin
            // cyc follows the owner, so it is already low in its release cycle.
            wbs_cyc_o_m = own_cyc;
            wbs_we_o_m  = wbs_we_i_mgr[owner_q];
            wbs_adr_o_m = wbs_adr_i_mgr[owner_q*WB_ADR_W +: WB_ADR_W];
            wbs_dat_o_m = wbs_dat_i_mgr[owner_q*WB_DAT_W +: WB_DAT_W];
            wbs_sel_o_m = wbs_sel_i_mgr[owner_q*WB_SEL_W +: WB_SEL_W];
        end
        unique case (state_q)
            OWNED: begin
                wbs_stb_o_m                                   = own_cyc & own_stb;
                wbs_ack_o_mgr[owner_q]                        = wbs_ack_i_m;
                wbs_dat_o_mgr[owner_q*WB_DAT_W +: WB_DAT_W]   = wbs_dat_i_m;
            end
            FORCE: begin
                // Decoder response is ignored here; stb is withdrawn downstream.
                wbs_ack_o_mgr[owner_q]                        = 1'b1;
                wbs_dat_o_mgr[owner_q*WB_DAT_W +: WB_DAT_W]   = TIMEOUT_DATA;
                timeout_o                                     = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_o = grant_q;

endmodule : wishbone_arbiter

// File: tb/tb_wishbone_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wishbone_arbiter
// Directed bench for wishbone_arbiter with 3 managers and an 8-cycle watchdog.
// A vector table exercises round-robin selection from IDLE; hand-written
// sequences cover transfers, hold, timeout, reset and late-ack corners.
// ---------------------------------------------------------------------------
module tb_wishbone_arbiter;

    localparam int N = 3;
    localparam int T = 8;

    logic            CLK = 1'b0;
    logic            RST;
    logic [N-1:0]    cyc, stb, we;
    logic [32*N-1:0] adr, wdat;
    logic [4*N-1:0]  sel;
    logic [N-1:0]    ack_mgr;
    logic [32*N-1:0] rdat_mgr;
    logic            cyc_m, stb_m, we_m;
    logic [31:0]     adr_m, dat_m;
    logic [3:0]      sel_m;
    logic            ack_m;
    logic [31:0]     rdat_m;
    logic [N-1:0]    grant;
    logic            timeout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    wishbone_arbiter #(
        .NUM_MANAGERS   (N),
        .TIMEOUT_CYCLES (T),
        .TIMEOUT_DATA   (32'hDEAD_BEEF)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .wbs_cyc_i_mgr (cyc),
        .wbs_stb_i_mgr (stb),
        .wbs_we_i_mgr  (we),
        .wbs_adr_i_mgr (adr),
        .wbs_dat_i_mgr (wdat),
        .wbs_sel_i_mgr (sel),
        .wbs_ack_o_mgr (ack_mgr),
        .wbs_dat_o_mgr (rdat_mgr),
        .wbs_cyc_o_m   (cyc_m),
        .wbs_stb_o_m   (stb_m),
        .wbs_we_o_m    (we_m),
        .wbs_adr_o_m   (adr_m),
        .wbs_dat_o_m   (dat_m),
        .wbs_sel_o_m   (sel_m),
        .wbs_ack_i_m   (ack_m),
        .wbs_dat_i_m   (rdat_m),
        .grant_o       (grant),
        .timeout_o     (timeout)
    );

    typedef struct packed {
        logic [N-1:0] req;
        logic [N-1:0] exp_grant;
    } arb_vec_t;

    arb_vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic set_mgr(input int k, input logic c, input logic s, input logic w,
                           input logic [31:0] a, input logic [31:0] d, input logic [3:0] sl);
        cyc[k]          = c;
        stb[k]          = s;
        we[k]           = w;
        adr[k*32 +: 32] = a;
        wdat[k*32 +: 32] = d;
        sel[k*4 +: 4]   = sl;
    endtask

    task automatic idle_all();
        cyc    = '0;
        stb    = '0;
        we     = '0;
        adr    = '0;
        wdat   = '0;
        sel    = '0;
        ack_m  = 1'b0;
        rdat_m = '0;
    endtask

    task automatic do_reset();
        idle_all();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no end of test, expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        // ptr evolution from reset: 0,1,2,0,2,1,0,0,1 -> ends at 0
        vecs[0] = '{req: 3'b111, exp_grant: 3'b001};
        vecs[1] = '{req: 3'b111, exp_grant: 3'b010};
        vecs[2] = '{req: 3'b111, exp_grant: 3'b100};
        vecs[3] = '{req: 3'b110, exp_grant: 3'b010};
        vecs[4] = '{req: 3'b001, exp_grant: 3'b001};
        vecs[5] = '{req: 3'b101, exp_grant: 3'b100};
        vecs[6] = '{req: 3'b100, exp_grant: 3'b100};
        vecs[7] = '{req: 3'b011, exp_grant: 3'b001};
        vecs[8] = '{req: 3'b101, exp_grant: 3'b100};

        // ---- reset state ----
        idle_all();
        RST = 1'b1;
        #12;
        check("rst grant", grant, 0);
        check("rst cyc_o_m", cyc_m, 0);
        check("rst stb_o_m", stb_m, 0);
        check("rst ack_mgr", ack_mgr, 0);
        check("rst dat_mgr", rdat_mgr, 0);
        check("rst timeout", timeout, 0);
        step();
        RST = 1'b0;
        #1;

        // ---- table: round-robin pick from IDLE ----
        for (int i = 0; i < 9; i++) begin
            cyc = vecs[i].req;
            step();
            #1;
            check($sformatf("vec%0d grant", i), grant, vecs[i].exp_grant);
            check($sformatf("vec%0d cyc_o_m", i), cyc_m, 1);
            cyc = '0;
            #1;
            check($sformatf("vec%0d drop cyc_o_m", i), cyc_m, 0);
            step();
            #1;
            check($sformatf("vec%0d idle grant", i), grant, 0);
        end

        // ---- 1: single manager write ----
        do_reset();
        set_mgr(1, 1'b1, 1'b1, 1'b1, 32'h3000_0004, 32'h1234_5678, 4'hF);
        #1;
        check("t1 latency grant", grant, 0);
        check("t1 latency cyc_o_m", cyc_m, 0);
        step();
        #1;
        check("t1 grant", grant, 3'b010);
        check("t1 adr", adr_m, 32'h3000_0004);
        check("t1 dat", dat_m, 32'h1234_5678);
        check("t1 sel", sel_m, 4'hF);
        check("t1 we", we_m, 1);
        check("t1 stb", stb_m, 1);
        check("t1 no early ack", ack_mgr, 0);
        step();
        ack_m = 1'b1;
        #1;
        check("t1 ack to m1 only", ack_mgr, 3'b010);
        step();
        ack_m = 1'b0;
        set_mgr(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("t1 ack gone", ack_mgr, 0);
        check("t1 release cyc_o_m", cyc_m, 0);
        step();
        #1;
        check("t1 idle grant", grant, 0);

        // ---- 2: contention from reset ----
        do_reset();
        cyc = 3'b111;
        step();
        #1;
        check("t2 first grant", grant, 3'b001);
        cyc[0] = 1'b0;
        #1;
        check("t2 m0 drop cyc_o_m", cyc_m, 0);
        step();
        #1;
        check("t2 idle after m0", grant, 0);
        step();
        #1;
        check("t2 second grant", grant, 3'b010);
        cyc[1] = 1'b0;
        step();
        step();
        #1;
        check("t2 third grant", grant, 3'b100);
        cyc[2] = 1'b0;
        step();
        cyc[0] = 1'b1;
        step();
        #1;
        check("t2 wrap grant", grant, 3'b001);
        cyc[0] = 1'b0;
        step();

        // ---- 3: hold while another waits ----
        do_reset();
        set_mgr(0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
        step();
        #1;
        check("t3 m0 grant", grant, 3'b001);
        set_mgr(2, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
        for (int b = 0; b < 3; b++) begin
            stb[0] = 1'b1;
            ack_m  = 1'b1;
            #1;
            check($sformatf("t3 beat%0d ack", b), ack_mgr, 3'b001);
            check($sformatf("t3 beat%0d adr", b), adr_m, 32'h0000_0100);
            step();
            stb[0] = 1'b0;
            ack_m  = 1'b0;
            #1;
            check($sformatf("t3 beat%0d hold", b), grant, 3'b001);
            step();
        end
        cyc[0] = 1'b0;
        #1;
        check("t3 release cyc_o_m", cyc_m, 0);
        step();
        #1;
        check("t3 idle", grant, 0);
        step();
        #1;
        check("t3 m2 grant", grant, 3'b100);
        check("t3 m2 stb", stb_m, 1);

        // ---- 4: watchdog forced ack ----
        do_reset();
        rdat_m = 32'h0BAD_0BAD;
        set_mgr(2, 1'b1, 1'b1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
        step();
        #1;
        check("t4 grant", grant, 3'b100);
        for (int k = 0; k < T; k++) begin
            check($sformatf("t4 wait%0d ack", k), ack_mgr, 0);
            check($sformatf("t4 wait%0d timeout", k), timeout, 0);
            step();
            #1;
        end
        check("t4 forced ack", ack_mgr, 3'b100);
        check("t4 forced dat", rdat_mgr[95:64], 32'hDEAD_BEEF);
        check("t4 timeout pulse", timeout, 1);
        check("t4 stb withdrawn", stb_m, 0);
        check("t4 cyc kept", cyc_m, 1);
        set_mgr(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_mgr(0, 1'b1, 1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
        step();
        #1;
        check("t4 pulse ends", timeout, 0);
        check("t4 no ack after", ack_mgr, 0);
        step();
        #1;
        check("t4 idle", grant, 0);
        step();
        #1;
        check("t4 m0 grant", grant, 3'b001);
        stb[0] = 1'b1;
        ack_m  = 1'b1;
        #1;
        check("t4 m0 ack", ack_mgr, 3'b001);
        check("t4 m0 dat", rdat_mgr[31:0], 32'h0BAD_0BAD);
        step();

        // ---- 5: reset mid-transfer ----
        do_reset();
        set_mgr(1, 1'b1, 1'b1, 1'b1, 32'h0000_0800, 32'hCAFE_0001, 4'h3);
        step();
        #1;
        check("t5 grant", grant, 3'b010);
        check("t5 stb", stb_m, 1);
        RST = 1'b1;
        #1;
        check("t5 async grant", grant, 0);
        check("t5 async cyc_o_m", cyc_m, 0);
        check("t5 async stb_o_m", stb_m, 0);
        step();
        RST = 1'b0;
        idle_all();
        set_mgr(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        #1;
        check("t5 m0 grant", grant, 3'b001);

        // ---- 6: ack in the cycle the owner drops cyc ----
        do_reset();
        set_mgr(0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
        set_mgr(1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
        step();
        #1;
        check("t6 grant", grant, 3'b001);
        step();
        cyc[0] = 1'b0;
        stb[0] = 1'b0;
        ack_m  = 1'b1;
        #1;
        check("t6 late ack to m0", ack_mgr, 3'b001);
        check("t6 cyc_o_m low", cyc_m, 0);
        step();
        #1;
        check("t6 idle", grant, 0);
        check("t6 idle ack discarded", ack_mgr, 0);
        ack_m = 1'b0;
        step();
        #1;
        check("t6 m1 grant", grant, 3'b010);
        check("t6 m1 no spurious ack", ack_mgr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_wishbone_arbiter
